// File: rtl/mash_ddsm_param_pkg.sv
// mash_ddsm_param_pkg: shared constants and helpers for the MASH delta-sigma modulator.
package mash_ddsm_param_pkg;
    localparam int NET_W = 4;
    // Fibonacci taps 16,15,13,4 -> bits 15,14,12,3
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    function automatic logic [2:0] clamp_order(input logic [2:0] req, input int max_order);
        return (req == 3'd0) ? 3'd1 : ((int'(req) > max_order) ? 3'(max_order) : req);
    endfunction

    function automatic int sat_range(input int x, input int hi);
        return (x < 0) ? 0 : ((x > hi) ? hi : x);
    endfunction
endpackage

// File: rtl/mash_ddsm_param_acc_stage.sv
// mash_ddsm_param_acc_stage: one modulo-2^W accumulator with registered carry, enable/clear and offset.
module mash_ddsm_param_acc_stage
    import mash_ddsm_param_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W:0]   addend,
    input  logic [W-1:0] offset,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [W-1:0] acc;
    logic [W:0]   total;

    assign total = {1'b0, acc} + addend;
    assign sum   = total[W-1:0];

    // offset shifts the stored phase only; its wrap never reaches the carry
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            acc   <= sum + offset;
            carry <= total[W];
        end
    end
endmodule

// File: rtl/mash_ddsm_param.sv
// mash_ddsm_param: run-time order MASH 1-1-..-1 modulator with double-buffered config,
// one-shot phase offset, LFSR dither and a saturated integer+fraction divider word.
module mash_ddsm_param
    import mash_ddsm_param_pkg::*;
#(
    parameter int FRAC_W    = 24,
    parameter int INT_W     = 8,
    parameter int ORDER_MAX = 4,
    parameter int LFSR_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cfg_we,
    input  logic [FRAC_W-1:0]       i_frac,
    input  logic [INT_W-1:0]        i_int,
    input  logic [2:0]              i_order,
    input  logic                    i_dither_en,
    input  logic                    i_seed_load,
    input  logic [LFSR_W-1:0]       i_seed,
    input  logic                    i_phase_req,
    input  logic [FRAC_W-1:0]       i_phase,
    output logic                    o_phase_ack,
    output logic [INT_W-1:0]        o_div,
    output logic signed [NET_W-1:0] o_net,
    output logic                    o_sat
);
    localparam int AW      = FRAC_W + 1;
    localparam int DW      = INT_W + 2;
    localparam int DIV_MAX = 2 ** INT_W - 1;

    logic [FRAC_W-1:0] sh_frac, act_frac, ph_val;
    logic [INT_W-1:0]  sh_int, act_int;
    logic [2:0]        sh_order, order;
    logic              sh_dither, act_dither;
    logic [LFSR_W-1:0] lfsr;
    logic              ph_pend, ph_done;
    logic [AW-1:0]     stage_in  [ORDER_MAX];
    logic [FRAC_W-1:0] stage_sum [ORDER_MAX];
    logic [ORDER_MAX-1:0] carry;
    logic signed [NET_W-1:0] net_in [ORDER_MAX];
    logic signed [DW-1:0] div_sum;

    // stage gating follows the order that becomes active at this edge
    assign order       = clamp_order(sh_order, ORDER_MAX);
    assign stage_in[0] = {1'b0, act_frac} + AW'(act_dither & lfsr[0]);

    for (genvar k = 0; k < ORDER_MAX; k++) begin : g_stage
        if (k > 0) begin : g_chain
            assign stage_in[k] = {1'b0, stage_sum[k-1]};
        end
        mash_ddsm_param_acc_stage #(.W(FRAC_W)) u_stage (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .en     (3'(k) < order),
            .addend (stage_in[k]),
            .offset ((k == 0 && ph_pend) ? ph_val : '0),
            .sum    (stage_sum[k]),
            .carry  (carry[k])
        );
    end

    // nested differentiators: level m folds in carry ORDER_MAX-1-m delayed m-1 cycles
    assign net_in[0] = NET_W'(carry[ORDER_MAX-1]);

    for (genvar m = 1; m < ORDER_MAX; m++) begin : g_net
        logic cdv;
        logic signed [NET_W-1:0] q, p;
        if (m == 1) begin : g_nodly
            assign cdv = carry[ORDER_MAX-2];
        end else begin : g_dly
            localparam int D = m - 1;
            logic [D-1:0] dly;
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) dly <= '0;
                else dly <= D'({dly, carry[ORDER_MAX-1-m]});
            end
            assign cdv = dly[D-1];
        end
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                q <= '0;
                p <= '0;
            end else begin
                q <= NET_W'(cdv) + net_in[m-1] - p;
                p <= net_in[m-1];
            end
        end
        assign net_in[m] = q;
    end

    assign div_sum = $signed({2'b00, act_int}) + DW'(o_net);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_frac     <= '0;
            sh_int      <= '0;
            sh_order    <= '0;
            sh_dither   <= 1'b0;
            act_frac    <= '0;
            act_int     <= '0;
            act_dither  <= 1'b0;
            lfsr        <= LFSR_W'(1);
            ph_pend     <= 1'b0;
            ph_done     <= 1'b0;
            ph_val      <= '0;
            o_phase_ack <= 1'b0;
            o_net       <= '0;
            o_div       <= '0;
            o_sat       <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                sh_frac   <= i_frac;
                sh_int    <= i_int;
                sh_order  <= i_order;
                sh_dither <= i_dither_en;
            end
            act_frac    <= sh_frac;
            act_int     <= sh_int;
            act_dither  <= sh_dither;
            lfsr        <= i_seed_load ? ((i_seed == '0) ? LFSR_W'(1) : i_seed)
                                       : {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_W'(LFSR_TAPS))};
            ph_pend     <= i_phase_req && !ph_pend && !ph_done;
            ph_val      <= (i_phase_req && !ph_pend && !ph_done) ? i_phase : ph_val;
            ph_done     <= ph_pend;
            o_phase_ack <= ph_done;
            o_net       <= net_in[ORDER_MAX-1];
            o_div       <= INT_W'(sat_range(int'(div_sum), DIV_MAX));
            o_sat       <= (div_sum < 0) || (int'(div_sum) > DIV_MAX);
        end
    end
endmodule
